// File: rtl/jk_pkg.sv
// Shared types and the JK excitation table used by the excitation driver.
package jk_pkg;

    localparam logic DC_ZERO = 1'b0;
    localparam logic DC_ONE  = 1'b1;

    typedef struct packed {
        logic j;
        logic k;
    } jk_cmd_t;

    // Inputs that would move q from q_cur to q_next; the free input takes dc_mode.
    function automatic jk_cmd_t jk_excite(input logic q_cur, input logic q_next, input logic dc_mode);
        jk_cmd_t cmd;
        if (!q_cur) begin
            cmd.j = q_next;
            cmd.k = dc_mode;
        end else begin
            cmd.j = dc_mode;
            cmd.k = ~q_next;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/bit_fifo.sv
// 1-bit synchronous FIFO; DEPTH must be a power of 2 so pointers wrap naturally.
module bit_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     din,
    output logic                     dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == CW'(0));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/jk_excitation_driver.sv
// Turns a stream of target flip-flop states into registered J/K commands and
// checks the driven flip-flop's q two edges after each command.
module jk_excitation_driver
    import jk_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned DC_MODE  = 0,
    parameter int unsigned CHECK_EN = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tgt_valid,
    input  logic                     tgt_bit,
    output logic                     tgt_ready,
    input  logic                     en,
    input  logic                     clr_err,
    input  logic                     q_fb,
    output logic                     j,
    output logic                     k,
    output logic                     drv_valid,
    output logic                     q_model,
    output logic                     mismatch,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     idle
);

    localparam logic DC_BIT = (DC_MODE != 0) ? DC_ONE : DC_ZERO;
    localparam logic CHK_ON = (CHECK_EN != 0);

    logic    fifo_full;
    logic    fifo_empty;
    logic    head;
    logic    pop;
    logic    cmp_fail;
    jk_cmd_t cmd;
    logic [1:0] pipe_v;
    logic [1:0] pipe_e;

    // A clearing edge never pops, so the model resync sees a quiet flip-flop.
    assign pop       = en & ~fifo_empty & ~mismatch & ~clr_err;
    assign tgt_ready = ~fifo_full;
    assign cmd       = jk_excite(q_model, head, DC_BIT);
    assign cmp_fail  = CHK_ON & pipe_v[1] & (q_fb != pipe_e[1]);
    assign idle      = (count == '0) & ~pipe_v[0] & ~pipe_v[1];

    bit_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tgt_valid),
        .pop   (pop),
        .din   (tgt_bit),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    // Command registers, flip-flop model and the (valid, expected) compare pipe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            j         <= 1'b0;
            k         <= 1'b0;
            drv_valid <= 1'b0;
            q_model   <= 1'b0;
            mismatch  <= 1'b0;
            pipe_v    <= '0;
            pipe_e    <= '0;
        end else begin
            j         <= 1'b0;
            k         <= 1'b0;
            drv_valid <= 1'b0;
            if (clr_err) begin
                mismatch <= 1'b0;
                q_model  <= q_fb;
                pipe_v   <= '0;
                pipe_e   <= '0;
            end else begin
                pipe_v <= {pipe_v[0], pop};
                pipe_e <= {pipe_e[0], head};
                if (cmp_fail) begin
                    mismatch <= 1'b1;
                end
                if (pop) begin
                    j         <= cmd.j;
                    k         <= cmd.k;
                    drv_valid <= 1'b1;
                    q_model   <= head;
                end
            end
        end
    end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: DC_MODE 0 and 1 instances run in lockstep on
// modelled jk flip-flops, plus a CHECK_EN=0 instance whose q_fb is stuck at 0.
module tb_jk_excitation_driver;

    logic clk = 1'b0;
    logic rst;
    logic tgt_valid;
    logic tgt_bit;
    logic en;
    logic clr_err;
    logic fb_force;

    logic j0, k0, dv0, qm0, mm0, rdy0, idle0;
    logic j1, k1, dv1, qm1, mm1, rdy1, idle1;
    logic j2, k2, dv2, qm2, mm2, rdy2, idle2;
    logic [2:0] cnt0, cnt1, cnt2;
    logic ff0, ff1;
    logic fb0, fb1;

    int   checks   = 0;
    int   failures = 0;
    logic exp_q[$];
    logic q_exp = 1'b0;

    always #5 clk = ~clk;

    assign fb0 = fb_force ? 1'b0 : ff0;
    assign fb1 = fb_force ? 1'b0 : ff1;

    function automatic logic ff_next(input logic q, input logic jj, input logic kk);
        case ({jj, kk})
            2'b00:   return q;
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            default: return ~q;
        endcase
    endfunction

    // Expected {j,k} from the excitation table with don't-cares resolved to dc.
    function automatic logic [1:0] exp_jk(input logic dc, input logic q, input logic nxt);
        case ({q, nxt})
            2'b00:   return {1'b0, dc};
            2'b01:   return {1'b1, dc};
            2'b10:   return {dc, 1'b1};
            default: return {dc, 1'b0};
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ff0 <= 1'b0;
            ff1 <= 1'b0;
        end else begin
            ff0 <= ff_next(ff0, j0, k0);
            ff1 <= ff_next(ff1, j1, k1);
        end
    end

    jk_excitation_driver #(.DEPTH(4), .DC_MODE(0), .CHECK_EN(1)) dut0 (
        .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit), .tgt_ready(rdy0),
        .en(en), .clr_err(clr_err), .q_fb(fb0), .j(j0), .k(k0), .drv_valid(dv0),
        .q_model(qm0), .mismatch(mm0), .count(cnt0), .idle(idle0)
    );

    jk_excitation_driver #(.DEPTH(4), .DC_MODE(1), .CHECK_EN(1)) dut1 (
        .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit), .tgt_ready(rdy1),
        .en(en), .clr_err(clr_err), .q_fb(fb1), .j(j1), .k(k1), .drv_valid(dv1),
        .q_model(qm1), .mismatch(mm1), .count(cnt1), .idle(idle1)
    );

    jk_excitation_driver #(.DEPTH(4), .DC_MODE(0), .CHECK_EN(0)) dut2 (
        .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit), .tgt_ready(rdy2),
        .en(en), .clr_err(clr_err), .q_fb(1'b0), .j(j2), .k(k2), .drv_valid(dv2),
        .q_model(qm2), .mismatch(mm2), .count(cnt2), .idle(idle2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge; offers b until both checked instances accept it, returns at a negedge.
    task automatic send(input logic b);
        bit ok;
        ok        = 1'b0;
        tgt_bit   = b;
        tgt_valid = 1'b1;
        for (int n = 0; n < 20 && !ok; n++) begin
            if (rdy0 && rdy1) begin
                @(posedge clk);
                exp_q.push_back(b);
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!ok) chk("send_timeout", {30'd0, rdy0, rdy1}, 32'd3);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (idle0 && idle1) ok = 1'b1;
        end
        if (!ok) chk("idle_timeout", {30'd0, idle0, idle1}, 32'd3);
    endtask

    // Scoreboard: every drv_valid consumes the oldest accepted target bit.
    always @(negedge clk) begin
        if (rst && (dv0 || dv1)) begin
            chk("dv0", dv0, 1);
            chk("dv1", dv1, 1);
            if (exp_q.size() == 0) begin
                chk("unexpected_drv", exp_q.size(), 1);
            end else begin
                logic b;
                b = exp_q.pop_front();
                chk("jk_dc0", {j0, k0}, exp_jk(1'b0, q_exp, b));
                chk("jk_dc1", {j1, k1}, exp_jk(1'b1, q_exp, b));
                chk("qm0", qm0, b);
                chk("qm1", qm1, b);
                q_exp = b;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        tgt_valid = 1'b1;
        tgt_bit   = 1'b1;
        en        = 1'b1;
        clr_err   = 1'b0;
        fb_force  = 1'b0;

        // Reset with the source offering data
        repeat (2) @(negedge clk);
        chk("rst_j0", j0, 0);
        chk("rst_k0", k0, 0);
        chk("rst_dv0", dv0, 0);
        chk("rst_cnt0", cnt0, 0);
        chk("rst_rdy0", rdy0, 1);
        chk("rst_idle0", idle0, 1);
        chk("rst_mm0", mm0, 0);
        chk("rst_qm0", qm0, 0);
        chk("rst_jk1", {j1, k1, dv1, qm1}, 0);
        chk("rst_jk2", {j2, k2, dv2, qm2}, 0);
        chk("rst_cnt2", cnt2, 0);
        tgt_valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        chk("post_rst_cnt0", cnt0, 0);
        chk("post_rst_idle1", idle1, 1);

        // Excitation stream on both DC modes
        send(1'b1); send(1'b1); send(1'b0); send(1'b0); send(1'b1);
        tgt_valid = 1'b0;
        wait_idle();
        chk("stream_mm0", mm0, 0);
        chk("stream_mm1", mm1, 0);
        chk("stream_ff0", ff0, 1);
        chk("stream_ff1", ff1, 1);

        // Fill, hold source when full, then push+pop at count 2
        en = 1'b0;
        send(1'b1); send(1'b0); send(1'b1); send(1'b1);
        chk("full_cnt", cnt0, 4);
        chk("full_rdy", rdy0, 0);
        tgt_bit = 1'b0;
        repeat (2) @(negedge clk);
        chk("held_cnt", cnt0, 4);
        chk("held_cnt1", cnt1, 4);
        tgt_valid = 1'b0;
        en        = 1'b1;
        for (int n = 0; n < 10 && cnt0 != 3'd2; n++) @(negedge clk);
        chk("drain_to_2", cnt0, 2);
        send(1'b0);
        chk("pushpop_cnt_a", cnt0, 2);
        send(1'b1);
        chk("pushpop_cnt_b", cnt0, 2);
        tgt_valid = 1'b0;
        wait_idle();
        chk("order_mm0", mm0, 0);
        chk("order_cnt", cnt0, 0);

        // Error path with q_fb stuck at 0
        fb_force = 1'b1;
        send(1'b1);
        tgt_valid = 1'b0;
        for (int n = 0; n < 4 && !dv0; n++) @(negedge clk);
        chk("err_dv", dv0, 1);
        chk("err_mm_e0", mm0, 0);
        @(negedge clk);
        chk("err_mm_e1", mm0, 0);
        @(negedge clk);
        chk("err_mm_e2_dut0", mm0, 1);
        chk("err_mm_e2_dut1", mm1, 1);
        send(1'b0); send(1'b0);
        tgt_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("blk_cnt", cnt0, 2);
        chk("blk_dv", dv0, 0);
        chk("blk_mm", mm0, 1);
        chk("nocheck_mm2", mm2, 0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        q_exp   = 1'b0;
        chk("clr_mm0", mm0, 0);
        chk("clr_mm1", mm1, 0);
        chk("clr_qm0", qm0, 0);
        chk("clr_qm1", qm1, 0);
        chk("clr_cnt", cnt0, 2);
        wait_idle();
        chk("resume_mm0", mm0, 0);
        chk("resume_cnt", cnt0, 0);
        chk("nocheck_mm2_end", mm2, 0);

        // Reset with data queued and a check in flight
        en = 1'b0;
        send(1'b1); send(1'b1); send(1'b1); send(1'b1);
        tgt_valid = 1'b0;
        en        = 1'b1;
        @(negedge clk);
        en = 1'b0;
        chk("mid_dv", dv0, 1);
        chk("mid_cnt", cnt0, 3);
        @(negedge clk);
        chk("mid_inflight", idle0, 0);
        rst = 1'b0;
        #1;
        chk("mid_rst_cnt", cnt0, 0);
        chk("mid_rst_dv", dv0, 0);
        chk("mid_rst_qm", qm0, 0);
        chk("mid_rst_idle", idle0, 1);
        chk("mid_rst_rdy", rdy0, 1);
        exp_q.delete();
        q_exp = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        en  = 1'b1;
        repeat (5) @(negedge clk);
        chk("after_rst_mm0", mm0, 0);
        chk("after_rst_mm1", mm1, 0);
        chk("after_rst_dv", dv0, 0);
        chk("after_rst_cnt", cnt0, 0);
        chk("after_rst_qm", qm0, 0);
        chk("after_rst_cnt2", cnt2, 0);
        chk("after_rst_rdy2", {rdy2, idle2}, 2'b11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jk_excitation_driver.md
Name: jk_excitation_driver

Overview:
- Driving end of the JK flip-flop interface; consumes a stream of desired next-state bits and emits per-cycle J/K commands to a downstream jk_ff.
- Uses the JK excitation table against an internal model of the flip-flop state.
- Checks the flip-flop's q fed back against the expected value and flags divergence.
- Sits between a stimulus/sequencer source and any jk_ff instance; also serves as the reusable bench driver.

Parameters:
- DEPTH, 4, target FIFO depth; power of 2, minimum 2.
- DC_MODE, 0, don't-care resolution in the excitation table: 0 = drive 0, 1 = drive 1.
- CHECK_EN, 1, 1 enables q_fb comparison; 0 forces mismatch low.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- tgt_valid  in  1  target bit offered.
- tgt_bit  in  1  desired next flip-flop state.
- tgt_ready  out  1  FIFO can accept a bit (= !full).
- en  in  1  drain enable.
- clr_err  in  1  clears mismatch, resyncs model, resumes draining.
- q_fb  in  1  q from the driven jk_ff.
- j  out  1  registered J command.
- k  out  1  registered K command.
- drv_valid  out  1  j/k carry a command this cycle.
- q_model  out  1  modelled flip-flop state after the current command.
- mismatch  out  1  sticky error flag.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.
- idle  out  1  FIFO empty and no check in flight.

Behaviour:
- Reset (rst=0, async assert, sync release):
  - j=0, k=0, drv_valid=0, q_model=0, mismatch=0, count=0, idle=1, tgt_ready=1.
  - FIFO flushed; in-flight checks discarded.
- Push: on a clk edge with tgt_valid & tgt_ready. tgt_ready depends only on full; there is no pass-through when full.
- Pop condition: en & !empty & !mismatch.
- On a pop edge E:
  - register j/k from excitation(q_model, head).
  - drv_valid=1; q_model<=head.
- Excitation table (d = don't-care, resolved per DC_MODE):
  - 0->0: J=0, K=d.
  - 0->1: J=1, K=d.
  - 1->0: J=d, K=1.
  - 1->1: J=d, K=0.
- No pop at an edge: j=0, k=0 (hold command), drv_valid=0, q_model unchanged.
- Latency:
  - push to drv_valid: minimum 1 cycle; a push to an empty FIFO pops on the next edge.
  - drv_valid to mismatch: 2 edges. The downstream flip-flop samples at E+1; q_fb is compared at E+2 against the captured target through a 2-stage (valid, expected) pipe.
- mismatch:
  - Set at the compare edge when CHECK_EN=1 and q_fb != expected.
  - Sticky; blocks pops. Pushes are still accepted until full.
  - Checks already in flight still complete; they cannot clear the flag.
- clr_err (sampled at an edge):
  - mismatch<=0, q_model<=q_fb, compare pipe cleared.
  - Takes priority over a mismatch being set on the same edge.
  - No pop on that edge.
- Simultaneous push and pop: count unchanged, order preserved.
- Pointer wrap-around at DEPTH is natural.
- idle = (count==0) & no valid stage in the compare pipe.
- Reset mid-operation: immediate flush; no further drv_valid; no mismatch from pre-reset commands.

Decomposition:
- Package jk_pkg:
  - DC_ZERO/DC_ONE constants.
  - jk_cmd_t struct (j, k).
  - function jk_excite(q_cur, q_next, dc_mode) returning jk_cmd_t.
- One sub-module: bit_fifo (DEPTH-parameterised 1-bit synchronous FIFO with push/pop/full/empty/count, same clk/rst).
- Top level holds q_model, output registers and the compare pipe.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with tgt_valid=1 -> j=k=0, drv_valid=0, count=0, tgt_ready=1, idle=1, mismatch=0. Nothing is pushed while in reset.
2. Excitation, DC_MODE=0, en=1, real jk_ff on q_fb: push 1,1,0,0,1 back-to-back -> (j,k)=(1,0),(0,0),(0,1),(0,0),(1,0) on consecutive drv_valid cycles; q_fb follows 1,1,0,0,1; mismatch stays 0.
3. Same stream with DC_MODE=1 -> (j,k)=(1,1),(1,0),(1,1),(0,1),(1,1); q_fb identical; no mismatch.
4. Full/stall: en=0, push 6 bits -> count=4, tgt_ready=0 after the 4th, bits 5-6 held by the source. en=1 with push and pop in the same cycle at count=2 -> count stays 2. Output order equals input order.
5. Error path: q_fb tied 0, push 1 -> drv_valid then mismatch=1 exactly 2 edges later. Further pops blocked (drv_valid=0, count holds). Pulse clr_err -> mismatch=0, q_model=0, draining resumes. CHECK_EN=0 never flags.
6. Reset mid-operation: count=3 with a check in flight, assert rst -> count=0, drv_valid=0, mismatch stays 0 after release, q_model=0.
